// File: rtl/pic_pkg.sv
// pic_pkg: shared constants and types for the pic_core_p accumulator core.
// Contents: instruction width, 4-bit opcode enum, GOTO prefix, FSM state enum.
// Used by pic_core_p, pic_core_p_if and pic_regfile via import pic_pkg::*.
package pic_pkg;

  localparam int IW = 12;

  // GOTO owns the whole 101x opcode space; decode it on IR[11:9] first.
  localparam logic [2:0] GOTO_PFX = 3'b101;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_MOVLW  = 4'h1,
    OP_ADDLW  = 4'h2,
    OP_ANDLW  = 4'h3,
    OP_MOVF   = 4'h4,
    OP_MOVWF  = 4'h5,
    OP_ADDWF  = 4'h6,
    OP_DECFSZ = 4'h7,
    OP_MOVIW  = 4'h8,
    OP_MOVWO  = 4'h9,
    OP_CALL   = 4'hC,
    OP_RETURN = 4'hD,
    OP_RSVD   = 4'hE,
    OP_HALT   = 4'hF
  } opcode_e;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  typedef enum logic [1:0] {
    FETCH = S_FETCH,
    EXEC  = S_EXEC,
    HALT  = S_HALT
  } state_e;

endpackage

// File: rtl/pic_core_p_if.sv
// pic_core_p_if: program-ROM fetch bus between the core and instruction memory.
// Signals: imem_addr/imem_rd from the core; imem_data/imem_valid back from ROM.
// imem_valid is only meaningful while imem_rd is high.
interface pic_core_p_if #(
  parameter int PC_W = 9
);
  import pic_pkg::*;

  logic [PC_W-1:0] imem_addr;
  logic            imem_rd;
  logic [IW-1:0]   imem_data;
  logic            imem_valid;

  modport master (output imem_addr, output imem_rd, input imem_data, input imem_valid);
  modport slave  (input imem_addr, input imem_rd, output imem_data, output imem_valid);

endinterface

// File: rtl/pic_regfile.sv
// pic_regfile: 2**RAM_AW x DATA_W file-register RAM, combinational read, write on clock edge.
// Ports: clk_i, we_i, addr_i (shared read/write address), wdata_i, rdata_o.
// Contents are not reset.
module pic_regfile #(
  parameter int DATA_W = 8,
  parameter int RAM_AW = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [RAM_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**RAM_AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pic_core_p.sv
// pic_core_p: multi-cycle 12-bit-instruction accumulator core (FETCH/EXEC/HALT FSM, W, Z/C, skip).
// Ports: CLK, CLR (async active-low), imem fetch bus (master), in_port, out_port, w_out, flag_z, flag_c, halted.
// Optional return stack for CALL/RETURN when PIC_STACK_EN is defined; otherwise both act as NOP.
module pic_core_p
  import pic_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 9,
  parameter int RAM_AW  = 5,
  parameter int STACK_D = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  pic_core_p_if.master      imem,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] w_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              skip_q, skip_d;
  logic              rd_q, rd_d;

  opcode_e           op;
  logic              is_goto;
  logic [DATA_W-1:0] k_val;
  logic [RAM_AW-1:0] f_addr;
  logic [DATA_W-1:0] rf_rdata, rf_wdata, dec_val;
  logic              rf_we;
  logic [DATA_W:0]   sum_k, sum_f;

  assign op      = opcode_e'(ir_q[11:8]);
  assign is_goto = (ir_q[11:9] == GOTO_PFX);
  assign k_val   = DATA_W'(ir_q[7:0]);
  assign f_addr  = ir_q[RAM_AW-1:0];
  // Carry is the extra top bit of a one-bit-wider sum.
  assign sum_k   = {1'b0, w_q} + {1'b0, k_val};
  assign sum_f   = {1'b0, w_q} + {1'b0, rf_rdata};
  assign dec_val = rf_rdata - DATA_W'(1);

  pic_regfile #(
    .DATA_W (DATA_W),
    .RAM_AW (RAM_AW)
  ) u_regfile (
    .clk_i   (CLK),
    .we_i    (rf_we),
    .addr_i  (f_addr),
    .wdata_i (rf_wdata),
    .rdata_o (rf_rdata)
  );

`ifdef PIC_STACK_EN
  localparam int SP_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [PC_W-1:0] stk_q [STACK_D];
  logic [SP_W-1:0] sp_q, sp_inc, sp_dec;
  logic            push, pop;

  // sp_q points at the next free slot; both directions wrap modulo STACK_D,
  // so overflow silently overwrites the oldest return address.
  assign sp_inc = (sp_q == SP_W'(STACK_D - 1)) ? '0 : sp_q + SP_W'(1);
  assign sp_dec = (sp_q == '0) ? SP_W'(STACK_D - 1) : sp_q - SP_W'(1);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sp_q <= '0;
      for (int i = 0; i < STACK_D; i++) stk_q[i] <= '0;
    end else if (push) begin
      stk_q[sp_q] <= pc_q + PC_W'(1);
      sp_q        <= sp_inc;
    end else if (pop) begin
      sp_q <= sp_dec;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    w_d      = w_q;
    out_d    = out_q;
    z_d      = z_q;
    c_d      = c_q;
    skip_d   = skip_q;
    rf_we    = 1'b0;
    rf_wdata = w_q;
`ifdef PIC_STACK_EN
    push     = 1'b0;
    pop      = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        // rd_q gates capture so a stray valid in the first cycle after reset is ignored.
        if (rd_q && imem.imem_valid) begin
          ir_d    = imem.imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_q + PC_W'(1);
        skip_d  = 1'b0;
        if (skip_q) begin
          // Skipped slot behaves as NOP regardless of opcode, PC still advances.
        end else if (is_goto) begin
          pc_d = ir_q[PC_W-1:0];
        end else begin
          case (op)
            OP_MOVLW: w_d = k_val;
            OP_ADDLW: begin
              w_d = sum_k[DATA_W-1:0];
              c_d = sum_k[DATA_W];
              z_d = (sum_k[DATA_W-1:0] == '0);
            end
            OP_ANDLW: begin
              w_d = w_q & k_val;
              z_d = ((w_q & k_val) == '0);
            end
            OP_MOVF: begin
              w_d = rf_rdata;
              z_d = (rf_rdata == '0);
            end
            OP_MOVWF: rf_we = 1'b1;
            OP_ADDWF: begin
              w_d = sum_f[DATA_W-1:0];
              c_d = sum_f[DATA_W];
              z_d = (sum_f[DATA_W-1:0] == '0);
            end
            OP_DECFSZ: begin
              rf_we    = 1'b1;
              rf_wdata = dec_val;
              skip_d   = (dec_val == '0);
            end
            OP_MOVIW: begin
              w_d = in_port;
              z_d = (in_port == '0);
            end
            OP_MOVWO: out_d = w_q;
`ifdef PIC_STACK_EN
            OP_CALL: begin
              push = 1'b1;
              pc_d = PC_W'(ir_q[7:0]);
            end
            OP_RETURN: begin
              pop  = 1'b1;
              pc_d = stk_q[sp_dec];
            end
`endif
            OP_HALT: state_d = HALT;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
    rd_d = (state_d == FETCH);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      w_q     <= '0;
      out_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      skip_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      w_q     <= w_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
      skip_q  <= skip_d;
      rd_q    <= rd_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign imem.imem_rd   = rd_q;
  assign out_port       = out_q;
  assign w_out          = w_q;
  assign flag_z         = z_q;
  assign flag_c         = c_q;
  assign halted         = (state_q == HALT);

endmodule
